regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
//   Shares the single 64-bit register-file read port (32:1 x 64 read mux) among
//   NREQ requesters, e.g. decode operand fetch and the debug/trace port.
//   - Round-robin grant; valid/ready on both request and response sides.
//   - One registered response per accepted request, tagged with the requester id.
//   - Enforces the X31 == 0 rule independently of the mux input.
//   Sits between the requesters and the read-mux select/data pins.
// PARAMETERS
//   NREQ  2   number of requesters (2..8)
//   IDW   1   width of requester id = $clog2(NREQ); minimum 1
// PORTS
//   clk        in   1         clock, rising edge
//   reset      in   1         asynchronous, active-high reset
//   req_valid  in   NREQ      requester i has a read pending
//   req_reg    in   NREQ*5    register number; requester i uses bits [5i+4:5i]
//   req_ready  out  NREQ      one-hot accept strobe; at most one bit high
//   rd_sel     out  5         drives read_reg of the read mux
//   rd_data    in   64        read-mux output, combinational from rd_sel
//   rsp_valid  out  1         response holds valid data
//   rsp_id     out  IDW       requester that owns the response
//   rsp_data   out  64        registered read data
//   rsp_ready  in   1         consumer takes the response
// BEHAVIOUR
//   - States:
//     - IDLE: rsp_valid = 0.
//     - RESP: rsp_valid = 1.
//   - Reset:
//     - Forces IDLE, rsp_valid = 0, rsp_id = 0, rsp_data = 0.
//     - Sets the RR pointer to NREQ-1, so requester 0 wins first.
//   - can_accept = (state == IDLE) | (state == RESP & rsp_ready).
//   - Grant g: first i with req_valid[i], scanning from ptr+1 upward with wrap-around.
//     - Combinational from req_valid and ptr.
//     - req_ready[g] = can_accept & |req_valid; all other bits are 0.
//   - rd_sel:
//     - Equals req_reg[g] in the accept cycle.
//     - Otherwise 5'd31, which is benign and zero-valued.
//   - On an accept edge:
//     - rsp_data <= (req_reg[g] == 31) ? 64'h0 : rd_data.
//     - rsp_id <= g.
//     - ptr <= g.
//     - Next state is RESP.
//   - Latency:
//     - Request accepted in cycle N; response valid in cycle N+1.
//     - Throughput 1 per cycle while rsp_ready stays high.
//   - RESP with rsp_ready = 0:
//     - rsp_valid, rsp_id and rsp_data hold stable.
//     - req_ready = 0 and ptr is unchanged.
//   - RESP with rsp_ready = 1:
//     - With no req_valid: next state is IDLE.
//     - Otherwise a new accept happens in the same cycle (back-to-back).
//   - The pointer moves only on an accept; no requester starves.
//   - Worst-case wait is NREQ-1 grants.
//   - Requesters must hold req_valid and req_reg stable until req_ready.
//     - The arbiter does not latch an unaccepted request.
//   - Reset asserted mid-response: the response is dropped; rsp_valid falls immediately (async).
// TESTING
//   - Reset: reset = 1 with req_valid = 2'b11 -> req_ready = 0 and rsp_valid = 0.
//     - After release, requester 0 is granted first.
//   - Single read: mux in[j] = j*64'h0101; req0 reads r5 -> rd_sel = 5 in cycle N.
//     - Cycle N+1: rsp_valid = 1, rsp_id = 0, rsp_data = 64'h0505.
//   - X31: req1 reads r31 with rd_data forced to 64'hDEAD -> rsp_data = 0, rsp_id = 1.
//   - Round-robin: both requesters hold valid, rsp_ready = 1 -> grants alternate 0,1,0,1.
//     - One response per cycle.
//   - Backpressure: rsp_ready = 0 for 3 cycles -> rsp_* stable and req_ready = 0.
//     - When rsp_ready rises, the next grant lands in that same cycle.
//   - Mid-op reset: assert reset while rsp_valid = 1 -> rsp_valid = 0 asynchronously.
//     - After release, the pointer is back at 0-first order.

Source files
------------

// File: rtl/regfile_read_arbiter_if.sv
// Bus bundle between the register-file read arbiter and its environment:
// requester handshakes, the read-mux select/data pins and the response channel.
interface regfile_read_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_reg;
    logic [NREQ-1:0]   req_ready;
    logic [4:0]        rd_sel;
    logic [63:0]       rd_data;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [63:0]       rsp_data;
    logic              rsp_ready;

    // Arbiter side
    modport slave (
        input  req_valid, req_reg, rd_data, rsp_ready,
        output req_ready, rd_sel, rsp_valid, rsp_id, rsp_data
    );

    // Requester / mux / consumer side
    modport master (
        output req_valid, req_reg, rd_data, rsp_ready,
        input  req_ready, rd_sel, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the single 64-bit register-file read port among
// NREQ requesters. One registered, id-tagged response per accepted request;
// reads of x31 always return zero regardless of the mux output.
module regfile_read_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_read_arbiter_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [63:0]    rsp_data_q, rsp_data_d;

    logic [IDW-1:0] gnt;
    logic [IDW-1:0] scan_idx;
    logic           any_valid;
    logic           can_accept;
    logic           accept;
    logic [4:0]     gnt_reg;

    // x31 is hardwired to zero; never trust the mux for it
    function automatic logic [63:0] x31_mask(input logic [4:0] r, input logic [63:0] d);
        return (r == 5'd31) ? 64'h0 : d;
    endfunction

    // Round-robin search: first valid requester after the last winner, wrapping
    always_comb begin
        gnt       = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!any_valid && bus.req_valid[scan_idx]) begin
                any_valid = 1'b1;
                gnt       = scan_idx;
            end
        end
    end

    // Accept decision, accept strobe, mux select and next state; reset blocks accepts
    always_comb begin
        can_accept    = (state_q == IDLE) || (state_q == RESP && bus.rsp_ready);
        accept        = can_accept && any_valid && !reset;
        gnt_reg       = bus.req_reg[int'(gnt)*5 +: 5];
        bus.req_ready = '0;
        bus.rd_sel    = 5'd31;
        state_d       = state_q;
        ptr_d         = ptr_q;
        rsp_id_d      = rsp_id_q;
        if (accept) begin
            bus.req_ready[gnt] = 1'b1;
            bus.rd_sel         = gnt_reg;
            state_d            = RESP;
            ptr_d              = gnt;
            rsp_id_d           = gnt;
        end else if (state_q == RESP && bus.rsp_ready) begin
            state_d = IDLE;
        end
    end

    // Capture read data only on accept; kept apart from select logic to avoid a comb loop through the mux
    always_comb begin
        rsp_data_d = rsp_data_q;
        if (accept) begin
            rsp_data_d = x31_mask(gnt_reg, bus.rd_data);
        end
    end

    // State, pointer and response registers; reset makes requester 0 win first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= IDW'(NREQ - 1);
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_regfile_read_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_read_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    regfile_read_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stimulus drivers
    logic [NREQ-1:0] drv_valid;
    logic [4:0]      drv_reg [NREQ];
    logic            drv_rsp_ready;
    logic            force_dead;
    logic [63:0]     mem [32];

    always_comb begin
        bus.req_valid = drv_valid;
        bus.rsp_ready = drv_rsp_ready;
        bus.req_reg   = '0;
        for (int i = 0; i < NREQ; i++) bus.req_reg[5*i +: 5] = drv_reg[i];
    end

    // Register-file read mux: combinational from rd_sel
    always_comb bus.rd_data = force_dead ? 64'hDEAD : mem[bus.rd_sel];

    // Reference model: one outstanding response slot plus a round-robin pointer
    int          m_ptr;
    bit          m_valid;
    int          m_id;
    logic [63:0] m_data;
    bit          exp_acc;
    int          exp_g;

    int n_assert = 0;
    int n_fail   = 0;
    int waits [NREQ];
    int max_wait = 0;

    function automatic void model_reset();
        m_ptr   = NREQ - 1;
        m_valid = 0;
        m_id    = 0;
        m_data  = 64'h0;
    endfunction

    function automatic void model_eval();
        int g;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (g < 0 && drv_valid[i]) g = i;
        end
        exp_g   = g;
        exp_acc = !reset && (g >= 0) && (!m_valid || drv_rsp_ready);
    endfunction

    function automatic void model_clock();
        if (reset) begin
            model_reset();
        end else if (exp_acc) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i != exp_g && drv_valid[i]) begin
                    waits[i]++;
                    if (waits[i] > max_wait) max_wait = waits[i];
                end
            end
            waits[exp_g] = 0;
            m_valid = 1;
            m_id    = exp_g;
            m_ptr   = exp_g;
            if (drv_reg[exp_g] == 5'd31) m_data = 64'h0;
            else if (force_dead)         m_data = 64'hDEAD;
            else                         m_data = mem[drv_reg[exp_g]];
        end else if (m_valid && drv_rsp_ready) begin
            m_valid = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational and registered outputs at the negedge, then advance
    task automatic step();
        logic [63:0] e_rr;
        logic [63:0] e_sel;
        @(negedge clk);
        model_eval();
        e_rr  = 64'd0;
        e_sel = 64'd31;
        if (exp_acc) begin
            e_rr  = 64'd1 << exp_g;
            e_sel = 64'(drv_reg[exp_g]);
        end
        chk("req_ready", 64'(bus.req_ready), e_rr);
        chk("rd_sel",    64'(bus.rd_sel),    e_sel);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        chk("rsp_id",    64'(bus.rsp_id),    64'(m_id));
        chk("rsp_data",  bus.rsp_data,       m_data);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        logic [63:0] saved_data;
        logic [IDW-1:0] saved_id;

        reset         = 1'b1;
        drv_valid     = 2'b11;
        drv_reg[0]    = 5'd5;
        drv_reg[1]    = 5'd7;
        drv_rsp_ready = 1'b1;
        force_dead    = 1'b0;
        for (int j = 0; j < 32; j++) mem[j] = 64'(j) * 64'h0101;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        model_reset();

        // Reset held with both requesters valid: nothing accepted
        step();
        step();
        reset = 1'b0;

        // First grant after reset goes to requester 0
        step();
        chk("first_grant_id", 64'(bus.rsp_id), 64'd0);
        drv_valid = 2'b00;
        step();

        // Single read of r5 by requester 0
        drv_valid  = 2'b01;
        drv_reg[0] = 5'd5;
        step();
        drv_valid = 2'b00;
        chk("single_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_id",    64'(bus.rsp_id),    64'd0);
        chk("single_data",  bus.rsp_data,       64'h0505);
        step();

        // x31 read by requester 1 with the mux returning garbage
        force_dead = 1'b1;
        drv_valid  = 2'b10;
        drv_reg[1] = 5'd31;
        step();
        drv_valid = 2'b00;
        chk("x31_data", bus.rsp_data,       64'h0);
        chk("x31_id",   64'(bus.rsp_id),    64'd1);
        step();
        force_dead = 1'b0;

        // Round-robin with both requesters continuously valid
        drv_valid  = 2'b11;
        drv_reg[0] = 5'd3;
        drv_reg[1] = 5'd4;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_id",    64'(bus.rsp_id),    64'(i % 2));
            chk("rr_valid", 64'(bus.rsp_valid), 64'd1);
        end

        // Backpressure: response frozen, no accepts
        drv_rsp_ready = 1'b0;
        saved_data    = bus.rsp_data;
        saved_id      = bus.rsp_id;
        for (int i = 0; i < 3; i++) step();
        chk("bp_data_stable", bus.rsp_data,    saved_data);
        chk("bp_id_stable",   64'(bus.rsp_id), 64'(saved_id));
        drv_rsp_ready = 1'b1;
        step();
        chk("bp_release_id", 64'(bus.rsp_id), 64'd0);

        // Asynchronous reset while a response is pending
        chk("pre_reset_valid", 64'(bus.rsp_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("async_rst_data",  bus.rsp_data,       64'h0);
        model_reset();
        step();
        reset = 1'b0;
        step();
        chk("post_reset_id",    64'(bus.rsp_id),    64'd0);
        chk("post_reset_valid", 64'(bus.rsp_valid), 64'd1);

        // Random traffic: requesters hold their request until accepted
        for (int j = 0; j < 32; j++) mem[j] = {$urandom, $urandom};
        drv_valid = 2'b00;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        max_wait = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!drv_valid[i] && ($urandom % 2 == 0)) begin
                    drv_valid[i] = 1'b1;
                    drv_reg[i]   = 5'($urandom % 32);
                end
            end
            drv_rsp_ready = ($urandom % 4) != 0;
            step();
            if (exp_acc) drv_valid[exp_g] = 1'b0;
        end
        n_assert++;
        assert (max_wait <= NREQ - 1) else begin
            n_fail++;
            $error("FAIL max_wait observed=%0d expected<=%0d", max_wait, NREQ - 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
